// File: rtl/nes_pad_responder.sv
// Pad-side NES serial responder: captures buttons while latch is high and shifts
// them out active-low on data_n, one bit per synchronized pulse rising edge.
module nes_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BITS    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                latch,
    input  logic                pulse,
    input  logic [NUM_BITS-1:0] buttons,
    output logic                data_n,
    output logic [3:0]          bit_count,
    output logic                frame_done,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(NUM_BITS - 1);
    localparam logic [3:0] FULL     = 4'(NUM_BITS);

    state_t                   state;
    logic [SYNC_STAGES-1:0]   lat_sync;
    logic [SYNC_STAGES-1:0]   pul_sync;
    logic                     lat_d;
    logic                     pul_d;
    logic                     lat_s;
    logic                     pul_s;
    logic                     pul_rise;
    logic                     lat_fall;
    // Bit 0 goes straight to data_n on load, so only bits above it are held.
    logic [NUM_BITS-1:1]      shreg;

    assign lat_s     = lat_sync[SYNC_STAGES-1];
    assign pul_s     = pul_sync[SYNC_STAGES-1];
    assign pul_rise  = pul_s & ~pul_d;
    assign lat_fall  = ~lat_s & lat_d;
    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_sync <= '0;
            pul_sync <= '0;
            lat_d    <= 1'b0;
            pul_d    <= 1'b0;
        end else begin
            lat_sync <= {lat_sync[SYNC_STAGES-2:0], latch};
            pul_sync <= {pul_sync[SYNC_STAGES-2:0], pulse};
            lat_d    <= lat_s;
            pul_d    <= pul_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            data_n     <= 1'b1;
            bit_count  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_n <= 1'b1;
                    if (lat_s) state <= LOAD;
                end
                LOAD: begin
                    // Transparent while latch is high: follows button changes.
                    shreg     <= buttons[NUM_BITS-1:1];
                    data_n    <= ~buttons[0];
                    bit_count <= 4'd0;
                    if (lat_fall) state <= SHIFT;
                end
                SHIFT: begin
                    if (lat_s) begin
                        state     <= LOAD;
                        bit_count <= 4'd0;
                    end else if (pul_rise) begin
                        shreg <= shreg >> 1;
                        if (bit_count == LAST_BIT) begin
                            bit_count  <= FULL;
                            data_n     <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bit_count <= bit_count + 4'd1;
                            data_n    <= ~shreg[1];
                        end
                    end
                end
                DONE: begin
                    // Reads past the last bit return "pressed", as on real pads.
                    data_n <= 1'b0;
                    if (lat_s) begin
                        state     <= LOAD;
                        bit_count <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: default instance plus a SYNC_STAGES=3
// instance driven by the same reader lines for latency measurement.
module tb_nes_pad_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       latch = 1'b0;
    logic       pulse = 1'b0;
    logic [7:0] buttons = 8'h00;

    logic       data_n, frame_done;
    logic [3:0] bit_count;
    logic [1:0] state_dbg;
    logic       data_n3, frame_done3;
    logic [3:0] bit_count3;
    logic [1:0] state_dbg3;

    int passed = 0;
    int total = 0;
    int fd_count = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SHIFT = 2'd2, S_DONE = 2'd3;

    nes_pad_responder u_dut (
        .clock(clock), .reset(reset), .latch(latch), .pulse(pulse), .buttons(buttons),
        .data_n(data_n), .bit_count(bit_count), .frame_done(frame_done), .state_dbg(state_dbg)
    );

    nes_pad_responder #(.SYNC_STAGES(3), .NUM_BITS(8)) u_dut3 (
        .clock(clock), .reset(reset), .latch(latch), .pulse(pulse), .buttons(buttons),
        .data_n(data_n3), .bit_count(bit_count3), .frame_done(frame_done3), .state_dbg(state_dbg3)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n edges; sample 1 time unit after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (frame_done === 1'b1) fd_count++;
        end
    endtask

    task automatic pulse_once();
        pulse = 1'b1;
        tick(5);
        pulse = 1'b0;
        tick(5);
    endtask

    task automatic latch_frame();
        latch = 1'b1;
        tick(6);
        latch = 1'b0;
        tick(6);
    endtask

    // seq[0] is data_n right after the latch, seq[i] after pulse i.
    task automatic check_frame(input string tag, input logic [7:0] seq);
        fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) pulse_once();
            check($sformatf("%s_bit%0d", tag, i), 32'(data_n), 32'(seq[i]));
        end
        check({tag, "_no_early_done"}, fd_count, 0);
        check({tag, "_count7"}, 32'(bit_count), 7);
        pulse_once();
        check({tag, "_last_data"}, 32'(data_n), 0);
        check({tag, "_done_once"}, fd_count, 1);
        check({tag, "_count8"}, 32'(bit_count), 8);
        check({tag, "_state_done"}, 32'(state_dbg), 32'(S_DONE));
    endtask

    initial begin
        int lat_m, lat_3;

        // Reset with reader lines toggling
        for (int i = 0; i < 3; i++) begin
            latch = ~latch;
            pulse = ~pulse;
            tick(1);
        end
        check("rst_data_n", 32'(data_n), 1);
        check("rst_bit_count", 32'(bit_count), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        latch = 1'b0;
        pulse = 1'b0;
        reset = 1'b0;
        tick(5);
        check("idle_data_n", 32'(data_n), 1);
        check("idle_state", 32'(state_dbg), 32'(S_IDLE));

        // Normal frame: A and Right pressed
        buttons = 8'b1000_0001;
        latch_frame();
        check("norm_state_shift", 32'(state_dbg), 32'(S_SHIFT));
        check_frame("norm", 8'b0111_1110);
        fd_count = 0;
        pulse_once();
        pulse_once();
        check("past_end_data", 32'(data_n), 0);
        check("past_end_count", 32'(bit_count), 8);
        check("past_end_no_done", fd_count, 0);

        // Transparent load follows button changes while latch is high
        buttons = 8'h01;
        latch = 1'b1;
        tick(6);
        check("transp_first", 32'(data_n), 0);
        check("transp_state", 32'(state_dbg), 32'(S_LOAD));
        buttons = 8'h02;
        tick(3);
        check("transp_second", 32'(data_n), 1);
        latch = 1'b0;
        tick(6);
        check_frame("transp", 8'b1111_1101);

        // Latch priority: pulse coincident with latch rise and pulses while latched
        buttons = 8'h81;
        latch = 1'b1;
        pulse = 1'b1;
        tick(6);
        pulse = 1'b0;
        tick(5);
        pulse = 1'b1;
        tick(5);
        pulse = 1'b0;
        tick(5);
        check("prio_hold_count", 32'(bit_count), 0);
        check("prio_hold_data", 32'(data_n), 0);
        check("prio_hold_state", 32'(state_dbg), 32'(S_LOAD));
        latch = 1'b0;
        tick(6);
        check("prio_fall_count", 32'(bit_count), 0);
        check("prio_fall_data", 32'(data_n), 0);
        check("prio_fall_state", 32'(state_dbg), 32'(S_SHIFT));
        for (int i = 0; i < 3; i++) pulse_once();
        check("prio_three_count", 32'(bit_count), 3);
        check("prio_three_data", 32'(data_n), 1);
        buttons = 8'hFF;
        fd_count = 0;
        latch = 1'b1;
        tick(6);
        check("prio_reload_data", 32'(data_n), 0);
        check("prio_reload_count", 32'(bit_count), 0);
        check("prio_reload_state", 32'(state_dbg), 32'(S_LOAD));
        check("prio_reload_no_done", fd_count, 0);
        latch = 1'b0;
        tick(6);

        // Mid-frame reset
        for (int i = 0; i < 4; i++) pulse_once();
        check("mid_count4", 32'(bit_count), 4);
        reset = 1'b1;
        tick(1);
        check("mid_rst_data", 32'(data_n), 1);
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("mid_rst_count", 32'(bit_count), 0);
        reset = 1'b0;
        tick(3);
        buttons = 8'h5A;
        latch_frame();
        check_frame("five_a", 8'b1010_0101);

        // Latency: latch edge to data_n, both sync depths
        buttons = 8'h02;
        lat_m = 0;
        lat_3 = 0;
        latch = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (lat_m == 0 && data_n === 1'b1) lat_m = c;
            if (lat_3 == 0 && data_n3 === 1'b1) lat_3 = c;
        end
        check("latency_latch_s2", lat_m - 1, 3);
        check("latency_latch_s3", lat_3 - 1, 4);
        latch = 1'b0;
        tick(8);

        // Latency: pulse edge to next bit on data_n
        lat_m = 0;
        lat_3 = 0;
        pulse = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (lat_m == 0 && data_n === 1'b0) lat_m = c;
            if (lat_3 == 0 && data_n3 === 1'b0) lat_3 = c;
        end
        check("latency_pulse_s2", lat_m - 1, 2);
        check("latency_pulse_s3", lat_3 - 1, 3);
        check("latency_s3_count", 32'(bit_count3), 1);
        pulse = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
